// File: rtl/inst_encoder.sv
// RV32I instruction encoder: packs decoded fields plus a signed immediate into
// an instruction word, with range/alignment checks, one output register stage and wrapping counters.
module inst_encoder #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       fmt,
   input  logic [4:0]       rd,
   input  logic [4:0]       rs1,
   input  logic [4:0]       rs2,
   input  logic [2:0]       funct3,
   input  logic [6:0]       funct7,
   input  logic [31:0]      imm,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      inst,
   output logic             out_err,
   output logic [CNT_W-1:0] enc_count,
   output logic [CNT_W-1:0] err_count
);

   localparam logic [2:0] FMT_R    = 3'd0;
   localparam logic [2:0] FMT_I    = 3'd1;
   localparam logic [2:0] FMT_LOAD = 3'd2;
   localparam logic [2:0] FMT_S    = 3'd3;
   localparam logic [2:0] FMT_B    = 3'd4;

   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_LOAD = 7'b0000011;
   localparam logic [6:0] OP_S    = 7'b0100011;
   localparam logic [6:0] OP_B    = 7'b1100011;

   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   // Handshakes: a transfer happens on an edge where valid && ready. in_ready
   // depends only on the output register and out_ready, never on in_valid;
   // out_valid/inst/out_err hold steady while out_valid && !out_ready.

   logic             out_valid_q, out_valid_d;
   logic [31:0]      inst_q, inst_d;
   logic             out_err_q, out_err_d;
   logic [CNT_W-1:0] enc_count_q, enc_count_d;
   logic [CNT_W-1:0] err_count_q, err_count_d;

   logic        accept;
   logic        imm_fits_12;
   logic        imm_fits_13;
   logic [31:0] enc_inst;
   logic        enc_err;

   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   // Sign-extension checks: upper bits must all equal the top kept bit.
   assign imm_fits_12 = (&imm[31:11]) || !(|imm[31:11]);
   assign imm_fits_13 = (&imm[31:12]) || !(|imm[31:12]);

   always_comb begin
      enc_inst = NOP_INST;
      enc_err  = 1'b0;
      case (fmt)
         FMT_R: begin
            enc_inst = {funct7, rs2, rs1, funct3, rd, OP_R};
         end
         FMT_I: begin
            enc_inst = {imm[11:0], rs1, funct3, rd, OP_I};
            enc_err  = !imm_fits_12;
         end
         FMT_LOAD: begin
            enc_inst = {imm[11:0], rs1, funct3, rd, OP_LOAD};
            enc_err  = !imm_fits_12;
         end
         FMT_S: begin
            enc_inst = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_S};
            enc_err  = !imm_fits_12;
         end
         FMT_B: begin
            enc_inst = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_B};
            enc_err  = !imm_fits_13 || imm[0];
         end
         default: begin
            enc_err = 1'b1;
         end
      endcase
      if (enc_err) begin
         enc_inst = NOP_INST;
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      inst_d      = inst_q;
      out_err_d   = out_err_q;
      enc_count_d = enc_count_q;
      err_count_d = err_count_q;
      if (accept) begin
         out_valid_d = 1'b1;
         inst_d      = enc_inst;
         out_err_d   = enc_err;
         enc_count_d = enc_count_q + CNT_W'(1);
         if (enc_err) begin
            err_count_d = err_count_q + CNT_W'(1);
         end
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         inst_q      <= '0;
         out_err_q   <= 1'b0;
         enc_count_q <= '0;
         err_count_q <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         inst_q      <= inst_d;
         out_err_q   <= out_err_d;
         enc_count_q <= enc_count_d;
         err_count_q <= err_count_d;
      end
   end

   assign out_valid = out_valid_q;
   assign inst      = inst_q;
   assign out_err   = out_err_q;
   assign enc_count = enc_count_q;
   assign err_count = err_count_q;

endmodule
